// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and standard stage widths for pipeline stage registers.
package pipe_pkg;
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;
    localparam int IFID_W  = 64;
    localparam int IDEX_W  = 148;
    localparam int EXMEM_W = 107;
    localparam int MEMWB_W = 71;
    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_TWO   = ST_TWO
    } state_e;
endpackage

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: upstream and downstream valid/ready/data handshake of a pipeline stage.
interface pipe_stage_skid_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/pipe_stat_cnt.sv
// pipe_stat_cnt: wrapping statistics counter with enable, cleared only by rst.
module pipe_stat_cnt #(parameter int CNT_W = 32) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + 1'b1;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline stage register with 2-entry skid buffer and flush.
// Define PIPE_STAGE_STATS_EN to build the transfer/stall counters; otherwise they read 0.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_DATA = '0,
    parameter int               CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    pipe_stage_skid_if.slave  bus,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
    logic             out_valid_q, in_ready_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) state_d = S_EMPTY;
        else case (state_q)
            S_EMPTY: if (bus.in_valid) begin
                main_d  = bus.in_data;
                state_d = S_ONE;
            end
            S_ONE: begin
                if (bus.in_valid && bus.out_ready) main_d = bus.in_data;
                else if (bus.in_valid) begin
                    skid_d  = bus.in_data;
                    state_d = S_TWO;
                end
                else if (bus.out_ready) state_d = S_EMPTY;
            end
            S_TWO: if (bus.out_ready) begin
                main_d  = skid_q;
                state_d = S_ONE;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // in_ready/out_valid come from next-state so neither depends on out_ready combinationally
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= S_EMPTY;
            main_q      <= RESET_DATA;
            skid_q      <= RESET_DATA;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= state_d != S_EMPTY;
            in_ready_q  <= state_d != S_TWO;
        end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;

`ifdef PIPE_STAGE_STATS_EN
    pipe_stat_cnt #(.CNT_W(CNT_W)) u_xfer (
        .clk(clk), .rst(rst), .en_i(out_valid_q & bus.out_ready), .cnt_o(xfer_cnt)
    );
    pipe_stat_cnt #(.CNT_W(CNT_W)) u_stall (
        .clk(clk), .rst(rst), .en_i(out_valid_q & ~bus.out_ready), .cnt_o(stall_cnt)
    );
`else
    assign xfer_cnt  = '0;
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed checks of handshake, skid, flush, reset and counter wrap.
module tb_pipe_stage_skid;
    localparam int W = 8;
    localparam int CW = 4;
`ifdef PIPE_STAGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic clk, rst, flush;
    logic [CW-1:0] xfer_cnt, stall_cnt;
    int checks = 0;
    int errors = 0;

    pipe_stage_skid_if #(.WIDTH(W)) bus ();

    pipe_stage_skid #(.WIDTH(W), .RESET_DATA(8'h00), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus.slave),
        .xfer_cnt(xfer_cnt), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        flush         = f;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt(input int n);
        return STATS ? 32'(n % 16) : 32'd0;
    endfunction

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_xfer", 32'(xfer_cnt), 0);
        chk("rst_stall", 32'(stall_cnt), 0);

        step(1, 8'h11, 1, 0);
        chk("str_v1", 32'(bus.out_valid), 1);
        chk("str_d1", 32'(bus.out_data), 32'h11);
        step(1, 8'h22, 1, 0);
        chk("str_d2", 32'(bus.out_data), 32'h22);
        step(1, 8'h33, 1, 0);
        chk("str_d3", 32'(bus.out_data), 32'h33);
        step(0, 8'h00, 1, 0);
        chk("str_empty", 32'(bus.out_valid), 0);
        chk("str_xfer", 32'(xfer_cnt), cnt(3));
        chk("str_stall", 32'(stall_cnt), cnt(0));

        step(1, 8'hA1, 0, 0);
        chk("bp_d_a1", 32'(bus.out_data), 32'hA1);
        chk("bp_rdy_one", 32'(bus.in_ready), 1);
        step(1, 8'hA2, 0, 0);
        chk("bp_rdy_two", 32'(bus.in_ready), 0);
        chk("bp_hold_a1", 32'(bus.out_data), 32'hA1);
        step(1, 8'hA3, 0, 0);
        chk("bp_still_two", 32'(bus.in_ready), 0);
        chk("bp_stable_a1", 32'(bus.out_data), 32'hA1);
        chk("bp_stall", 32'(stall_cnt), cnt(2));
        step(1, 8'hA3, 1, 0);
        chk("bp_d_a2", 32'(bus.out_data), 32'hA2);
        chk("bp_rdy_back", 32'(bus.in_ready), 1);
        step(1, 8'hA3, 1, 0);
        chk("bp_d_a3", 32'(bus.out_data), 32'hA3);
        step(0, 8'h00, 1, 0);
        chk("bp_drained", 32'(bus.out_valid), 0);
        chk("bp_xfer", 32'(xfer_cnt), cnt(6));
        chk("bp_stall_end", 32'(stall_cnt), cnt(2));

        step(1, 8'hB1, 0, 0);
        step(1, 8'hB2, 0, 0);
        chk("fl_two", 32'(bus.in_ready), 0);
        step(1, 8'hB3, 0, 1);
        chk("fl_valid", 32'(bus.out_valid), 0);
        chk("fl_ready", 32'(bus.in_ready), 1);
        step(0, 8'h00, 1, 0);
        chk("fl_no_b3_valid", 32'(bus.out_valid), 0);
        chk("fl_data_kept", 32'(bus.out_data), 32'hB1);
        chk("fl_stall", 32'(stall_cnt), cnt(4));

        step(1, 8'hC1, 1, 0);
        chk("sim_one", 32'(bus.out_valid), 1);
        step(1, 8'hC2, 1, 1);
        chk("sim_empty", 32'(bus.out_valid), 0);
        chk("sim_ready", 32'(bus.in_ready), 1);
        chk("sim_dropped", 32'(bus.out_data), 32'hC1);
        chk("sim_xfer", 32'(xfer_cnt), cnt(7));

        step(1, 8'hD1, 0, 0);
        step(1, 8'hD2, 0, 0);
        chk("ar_two", 32'(bus.in_ready), 0);
        chk("ar_stall", 32'(stall_cnt), cnt(5));
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(bus.out_valid), 0);
        chk("ar_ready", 32'(bus.in_ready), 1);
        chk("ar_data", 32'(bus.out_data), 0);
        chk("ar_xfer", 32'(xfer_cnt), 0);
        chk("ar_stall0", 32'(stall_cnt), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 1; i <= 17; i++) begin
            step(1, 8'(i), 1, 0);
            chk("wrap_data", 32'(bus.out_data), 32'(i));
        end
        step(0, 8'h00, 1, 0);
        chk("wrap_xfer", 32'(xfer_cnt), cnt(17));
        chk("wrap_stall", 32'(stall_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-width IF_ID / ID_EX / EX_MEM / MEM_WB latches.
- Generic pipeline stage register with valid/ready handshake, a 2-entry skid buffer and a flush input.
- Sits between any two pipeline stages. Lets a downstream stall propagate upstream one cycle late with no data loss, and lets the hazard unit squash a stage (branch taken).

Parameters:
- WIDTH, 32, payload bits carried by the stage (e.g. 148 for ID/EX, 107 for EX/MEM, 71 for MEM/WB).
- RESET_DATA, 0, value loaded into the main and skid data registers on reset.
- CNT_W, 32, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  squash all held entries at the next clk edge.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept; driven directly from a register.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  main register holds a valid payload.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  WIDTH  main register payload.
- xfer_cnt  out  CNT_W  completed output transfers.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=EMPTY, out_valid=0, in_ready=1, out_data=RESET_DATA, skid data=RESET_DATA, counters=0. A reset mid-transfer discards all held data immediately, without waiting for a clock edge.
- Handshake rules:
  - An input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
  - Latency is 1 cycle: data accepted at edge N appears on out_data after edge N.
  - Throughput is 1 per cycle while out_ready=1.
- State machine:
  - EMPTY: out_valid=0, in_ready=1.
    - in_valid -> main<=in_data, go to ONE.
  - ONE: out_valid=1, in_ready=1.
    - in_valid & out_ready -> main<=in_data, stay in ONE.
    - !in_valid & out_ready -> EMPTY.
    - in_valid & !out_ready -> skid<=in_data, go to TWO.
    - neither -> hold.
  - TWO: out_valid=1, in_ready=0.
    - out_ready -> main<=skid, go to ONE.
    - otherwise hold.
    - in_valid is ignored while in TWO.
- in_ready is registered. It equals (next state != TWO), so it never depends combinationally on out_ready.
- Flush has priority over every transition. At the edge where flush=1:
  - state goes to EMPTY, out_valid=0, in_ready=1.
  - Any input offered in that cycle is dropped, even if in_ready=1.
  - Data registers are not cleared.
  - An output transfer in the same cycle still counts in xfer_cnt.
- out_data and the skid register are stable whenever their entry is valid and not consumed.
- Ordering is strictly FIFO: the skid entry is always emitted after the main entry.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- With the macro defined:
  - xfer_cnt increments on every output transfer.
  - stall_cnt increments on every cycle with out_valid & !out_ready.
  - Both counters wrap modulo 2^CNT_W and are cleared only by rst (flush does not clear them).
- Without the macro: xfer_cnt and stall_cnt are tied to 0 and no counter flops are built. Ports stay present so the interface is stable.

Decomposition:
- Shared package pipe_pkg holds:
  - the state encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2;
  - the standard stage widths IFID_W=64, IDEX_W=148, EXMEM_W=107, MEMWB_W=71.
- One sub-module, pipe_stat_cnt: a CNT_W-bit wrapping counter with enable, reset by rst. It is instantiated twice and only under PIPE_STAGE_STATS_EN.

Test Plan:
- Reset: assert rst mid-cycle with state TWO -> immediately out_valid=0, in_ready=1, out_data=0, both counters 0.
- Streaming: out_ready=1, send 0x11, 0x22, 0x33 on consecutive cycles -> out_data shows 0x11, 0x22, 0x33 one cycle later each; xfer_cnt=3, stall_cnt=0.
- Backpressure/skid: out_ready=0, send 0xA1 then 0xA2 -> state TWO, in_ready=0, 0xA3 held upstream. Raise out_ready -> outputs 0xA1, 0xA2, 0xA3 in order with no loss or duplication; stall_cnt equals the number of cycles out_ready was held low while out_valid=1.
- Flush: with 0xB1 in main and 0xB2 in skid, pulse flush while in_valid carries 0xB3 -> next cycle out_valid=0, in_ready=1, and 0xB3 never appears at the output.
- Simultaneous events: in ONE, in_valid=1, out_ready=1 and flush=1 in the same cycle -> xfer_cnt+1, state EMPTY, input dropped.
- Counter wrap (CNT_W=4): 17 transfers -> xfer_cnt=1. Without PIPE_STAGE_STATS_EN the same run gives xfer_cnt=0.
